// File: rtl/cmp_sub_pkg.sv
// Shared ALU definitions: default datapath width and condition-flag bit positions.
package cmp_sub_pkg;
  localparam int unsigned ALU_WIDTH = 32;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Signed less-than from the subtraction flags.
  function automatic logic signed_lt(input logic n, input logic v);
    return n ^ v;
  endfunction
endpackage

// File: rtl/cmp_sub_addsub.sv
// Combinational WIDTH-bit adder with carry-in and carry-out.
// Zero latency; no flow control.
module cmp_sub_addsub
  import cmp_sub_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];
endmodule

// File: rtl/cmp_sub.sv
// Registered compare/subtract: Out = In1 - In2 with NZCV flags and signed/unsigned relations.
// One-cycle latency, one operation per cycle, no backpressure; results hold while Valid_in is low.
module cmp_sub
  import cmp_sub_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid_in,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             Valid_out,
  output logic [WIDTH-1:0] Out,
  output logic             Carry,
  output logic             Overflow,
  output logic [3:0]       Flag,
  output logic             Lt_s,
  output logic             Lt_u,
  output logic             Eq
);
  logic [WIDTH-1:0] in2_n;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             ovf;

  logic             vld_d,  vld_q;
  logic [WIDTH-1:0] out_d,  out_q;
  logic [3:0]       flag_d, flag_q;
  logic             lt_s_d, lt_s_q;
  logic             lt_u_d, lt_u_q;
  logic             eq_d,   eq_q;

  assign in2_n = ~In2;

  cmp_sub_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (In1),
    .b    (in2_n),
    .cin  (1'b1),
    .sum  (diff),
    .cout (carry)
  );

  assign ovf = (In1[WIDTH-1] != In2[WIDTH-1]) && (diff[WIDTH-1] != In1[WIDTH-1]);

  // Relations are registered rather than derived from flag_q so every output reads 0 in reset.
  always_comb begin
    vld_d  = Valid_in;
    out_d  = out_q;
    flag_d = flag_q;
    lt_s_d = lt_s_q;
    lt_u_d = lt_u_q;
    eq_d   = eq_q;
    if (Valid_in) begin
      out_d          = diff;
      flag_d[FLAG_N] = diff[WIDTH-1];
      flag_d[FLAG_Z] = (diff == '0);
      flag_d[FLAG_C] = carry;
      flag_d[FLAG_V] = ovf;
      lt_s_d         = signed_lt(diff[WIDTH-1], ovf);
      lt_u_d         = ~carry;
      eq_d           = (diff == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      out_q  <= '0;
      flag_q <= '0;
      lt_s_q <= 1'b0;
      lt_u_q <= 1'b0;
      eq_q   <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      out_q  <= out_d;
      flag_q <= flag_d;
      lt_s_q <= lt_s_d;
      lt_u_q <= lt_u_d;
      eq_q   <= eq_d;
    end
  end

  assign Valid_out = vld_q;
  assign Out       = out_q;
  assign Flag      = flag_q;
  assign Carry     = flag_q[FLAG_C];
  assign Overflow  = flag_q[FLAG_V];
  assign Lt_s      = lt_s_q;
  assign Lt_u      = lt_u_q;
  assign Eq        = eq_q;
endmodule

// File: tb/tb_cmp_sub.sv
// Self-checking bench for cmp_sub: directed vectors, random streams, hold and reset behaviour.
module tb_cmp_sub;
  logic        clk;
  logic        rst;
  logic        Valid_in;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        Valid_out;
  logic [31:0] Out;
  logic        Carry;
  logic        Overflow;
  logic [3:0]  Flag;
  logic        Lt_s;
  logic        Lt_u;
  logic        Eq;

  int checks;
  int errors;

  // Reference state: last accepted result and the expected valid bit.
  logic        m_vld;
  logic [40:0] m_res;

  logic [41:0] obs;
  assign obs = {Valid_out, Out, Carry, Overflow, Flag, Lt_s, Lt_u, Eq};

  logic [31:0] ta [9];
  logic [31:0] tb_op [9];
  logic [31:0] tout [9];
  logic [1:0]  tcv [9];

  cmp_sub #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .Valid_in  (Valid_in),
    .In1       (In1),
    .In2       (In2),
    .Valid_out (Valid_out),
    .Out       (Out),
    .Carry     (Carry),
    .Overflow  (Overflow),
    .Flag      (Flag),
    .Lt_s      (Lt_s),
    .Lt_u      (Lt_u),
    .Eq        (Eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {Out, C, V, N, Z, C, V, Lt_s, Lt_u, Eq} from plain integer arithmetic.
  function automatic logic [40:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    longint      sd;
    logic        c;
    logic        v;
    d  = a - b;
    sd = longint'($signed(a)) - longint'($signed(b));
    c  = (a >= b);
    v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {d, c, v, d[31], (d == 32'd0), c, v, ($signed(a) < $signed(b)), (a < b), (a == b)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; Valid_in = 1'b0; In1 = '0; In2 = '0;
    m_vld = 1'b0; m_res = '0;
    #3;
    checks++;
    if (obs !== 42'd0) begin
      errors++;
      $display("FAIL reset_async obs=%h exp=%h", obs, 42'd0);
    end
    Valid_in = 1'b1; In1 = 32'd123; In2 = 32'd45;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 42'd0) begin
      errors++;
      $display("FAIL reset_held obs=%h exp=%h", obs, 42'd0);
    end
    @(negedge clk);
    rst = 1'b0; Valid_in = 1'b0;
  endtask

  task automatic test_directed();
    ta    = '{32'd10, 32'd10, 32'd7, 32'd5, 32'd0, 32'hFFFF8000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0};
    tb_op = '{32'd15, 32'hFFFFFFF1, 32'hFFFFFFFE, 32'd5, 32'hFFFFFFFF, 32'd32767, 32'hFFFFAC3C, 32'h80000001, 32'h80000000};
    tout  = '{32'hFFFFFFFB, 32'd25, 32'd9, 32'd0, 32'd1, 32'hFFFF0001, 32'h800053C3, 32'hFFFFFFFE, 32'h80000000};
    tcv   = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      Valid_in = 1'b1; In1 = ta[i]; In2 = tb_op[i];
      @(posedge clk);
      #1;
      m_vld = 1'b1; m_res = model(ta[i], tb_op[i]);
      checks++;
      if (Out !== tout[i]) begin
        errors++;
        $display("FAIL directed_out[%0d] got=%h exp=%h", i, Out, tout[i]);
      end
      checks++;
      if ({Carry, Overflow} !== tcv[i]) begin
        errors++;
        $display("FAIL directed_cv[%0d] got=%b exp=%b", i, {Carry, Overflow}, tcv[i]);
      end
      checks++;
      if (obs !== {m_vld, m_res}) begin
        errors++;
        $display("FAIL directed_all[%0d] got=%h exp=%h", i, obs, {m_vld, m_res});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      a = $urandom;
      b = (i % 7 == 0) ? a : ((i % 11 == 0) ? 32'h80000000 : $urandom);
      Valid_in = 1'b1; In1 = a; In2 = b;
      @(posedge clk);
      #1;
      m_vld = 1'b1; m_res = model(a, b);
      checks++;
      if (obs !== {m_vld, m_res}) begin
        errors++;
        $display("FAIL back_to_back[%0d] a=%h b=%h got=%h exp=%h", i, a, b, obs, {m_vld, m_res});
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      Valid_in = 1'b0; In1 = $urandom; In2 = $urandom;
      @(posedge clk);
      #1;
      m_vld = 1'b0;
      checks++;
      if (obs !== {m_vld, m_res}) begin
        errors++;
        $display("FAIL hold[%0d] got=%h exp=%h", i, obs, {m_vld, m_res});
      end
    end
  endtask

  task automatic test_random_mix();
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      v = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = ($urandom_range(0, 9) == 0) ? a : $urandom;
      Valid_in = v; In1 = a; In2 = b;
      @(posedge clk);
      #1;
      m_vld = v;
      if (v) m_res = model(a, b);
      checks++;
      if (obs !== {m_vld, m_res}) begin
        errors++;
        $display("FAIL random_mix[%0d] v=%b a=%h b=%h got=%h exp=%h", i, v, a, b, obs, {m_vld, m_res});
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    Valid_in = 1'b1; In1 = 32'h12345678; In2 = 32'h00000078;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_vld = 1'b0; m_res = '0;
    checks++;
    if (obs !== 42'd0) begin
      errors++;
      $display("FAIL reset_mid_async got=%h exp=%h", obs, 42'd0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 42'd0) begin
      errors++;
      $display("FAIL reset_mid_held got=%h exp=%h", obs, 42'd0);
    end
    @(negedge clk);
    rst = 1'b0; Valid_in = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 42'd0) begin
      errors++;
      $display("FAIL reset_mid_release got=%h exp=%h", obs, 42'd0);
    end
    @(negedge clk);
    Valid_in = 1'b1; In1 = 32'd3; In2 = 32'd9;
    @(posedge clk);
    #1;
    m_vld = 1'b1; m_res = model(32'd3, 32'd9);
    checks++;
    if (obs !== {m_vld, m_res}) begin
      errors++;
      $display("FAIL reset_mid_resume got=%h exp=%h", obs, {m_vld, m_res});
    end
    @(negedge clk);
    Valid_in = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_hold();
    test_random_mix();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
